// File: rtl/axi_stream_2_ppfifo.sv
// axi_stream_2_ppfifo
//
// AXI Stream slave that fills the write side of a dual-buffer ping-pong FIFO.
// A free buffer is claimed and accepted beats are written into it. The buffer
// is released when it is full or when the packet ends on tlast. A packet that
// overflows one buffer carries on into the next claimed buffer.
//
// Optional feature macro: AXI_KEEP_ERROR_EN
//   When defined, every accepted beat whose tkeep is not all-ones is counted
//   in a 16-bit saturating counter. When undefined, tkeep is ignored.
//
// Ports:
//   clk              clock for the AXI Stream and PPFIFO write interfaces
//   rst              synchronous, active-high reset
//   i_axi_valid      AXI Stream tvalid
//   o_axi_ready      AXI Stream tready (combinational from registers only)
//   i_axi_data       AXI Stream tdata
//   i_axi_keep       AXI Stream tkeep (data is always written whole)
//   i_axi_last       AXI Stream tlast
//   i_ppfifo_rdy     per-buffer "empty and available" flags
//   o_ppfifo_act     per-buffer "claimed for writing" flags, one-hot or zero
//   i_ppfifo_size    buffer capacity in words
//   o_ppfifo_stb     write strobe, one word per high cycle
//   o_ppfifo_data    write data
//   o_keep_err_count count of beats with partial tkeep (AXI_KEEP_ERROR_EN only)
//   i_keep_err_clear clears o_keep_err_count (AXI_KEEP_ERROR_EN only)

module axi_stream_2_ppfifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SIZE_WIDTH = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_axi_valid,
   output logic                    o_axi_ready,
   input  logic [DATA_WIDTH-1:0]   i_axi_data,
   input  logic [DATA_WIDTH/8-1:0] i_axi_keep,
   input  logic                    i_axi_last,
   input  logic [1:0]              i_ppfifo_rdy,
   output logic [1:0]              o_ppfifo_act,
   input  logic [SIZE_WIDTH-1:0]   i_ppfifo_size,
   output logic                    o_ppfifo_stb,
`ifdef AXI_KEEP_ERROR_EN
   output logic [15:0]             o_keep_err_count,
   input  logic                    i_keep_err_clear,
`endif
   output logic [DATA_WIDTH-1:0]   o_ppfifo_data
);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StWrite   = 2'd1,
      StRelease = 2'd2
   } state_e;

   state_e                state;
   logic [SIZE_WIDTH-1:0] r_count;
   logic [SIZE_WIDTH-1:0] r_size;
   logic [SIZE_WIDTH-1:0] count_inc;
   logic                  handshake;

   // Ready depends only on registered state so it never loops back through tvalid.
   assign o_axi_ready = (state == StWrite) && (r_count < r_size);
   assign handshake   = i_axi_valid && o_axi_ready;
   assign count_inc   = r_count + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= StIdle;
         o_ppfifo_act  <= 2'b00;
         o_ppfifo_stb  <= 1'b0;
         o_ppfifo_data <= '0;
         r_count       <= '0;
         r_size        <= '0;
      end else begin
         o_ppfifo_stb <= 1'b0;
         unique case (state)
            StIdle: begin
               // act must read zero before a new claim, giving the PPFIFO a cycle
               // to update rdy after a release.
               if ((o_ppfifo_act == 2'b00) && (i_ppfifo_rdy != 2'b00)) begin
                  o_ppfifo_act <= i_ppfifo_rdy[0] ? 2'b01 : 2'b10;
                  r_count      <= '0;
                  r_size       <= i_ppfifo_size;
                  state        <= StWrite;
               end
            end
            StWrite: begin
               if (!(r_count < r_size)) begin
                  // Zero-size buffer: hand it back without writing.
                  state <= StRelease;
               end else if (handshake) begin
                  o_ppfifo_stb  <= 1'b1;
                  o_ppfifo_data <= i_axi_data;
                  r_count       <= count_inc;
                  if (i_axi_last || (count_inc == r_size)) begin
                     state <= StRelease;
                  end
               end
            end
            StRelease: begin
               o_ppfifo_act <= 2'b00;
               state        <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

`ifdef AXI_KEEP_ERROR_EN
   always_ff @(posedge clk) begin
      if (rst || i_keep_err_clear) begin
         o_keep_err_count <= 16'h0000;
      end else if (handshake && !(&i_axi_keep) && (o_keep_err_count != 16'hFFFF)) begin
         o_keep_err_count <= o_keep_err_count + 16'h0001;
      end
   end
`else
   logic unused_keep;
   assign unused_keep = ^i_axi_keep;
`endif

endmodule

// File: tb/tb_axi_stream_2_ppfifo.sv
// Directed self-checking bench for axi_stream_2_ppfifo.
// Inputs change and outputs are sampled 1 time unit after each rising edge.

module tb_axi_stream_2_ppfifo;

   logic        clk;
   logic        rst;
   logic        valid;
   logic        ready;
   logic [31:0] data;
   logic [3:0]  keep;
   logic        last;
   logic [1:0]  rdy;
   logic [1:0]  act;
   logic [23:0] size;
   logic        stb;
   logic [31:0] pdata;
`ifdef AXI_KEEP_ERROR_EN
   logic [15:0] kcount;
   logic        kclear;
`endif

   int n_total;
   int n_pass;

   axi_stream_2_ppfifo #(
      .DATA_WIDTH(32),
      .SIZE_WIDTH(24)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .i_axi_valid     (valid),
      .o_axi_ready     (ready),
      .i_axi_data      (data),
      .i_axi_keep      (keep),
      .i_axi_last      (last),
      .i_ppfifo_rdy    (rdy),
      .o_ppfifo_act    (act),
      .i_ppfifo_size   (size),
      .o_ppfifo_stb    (stb),
`ifdef AXI_KEEP_ERROR_EN
      .o_keep_err_count(kcount),
      .i_keep_err_clear(kclear),
`endif
      .o_ppfifo_data   (pdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required end before 200000");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One accepted beat; the strobe and data are due on the following cycle.
   task automatic beat(input logic [31:0] d, input logic l, input string tag);
      valid = 1'b1;
      data  = d;
      last  = l;
      tick();
      chk({tag, "_stb"}, 64'(stb), 64'd1);
      chk({tag, "_data"}, 64'(pdata), 64'(d));
      valid = 1'b0;
      last  = 1'b0;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      rst     = 1'b1;
      valid   = 1'b0;
      data    = 32'h0;
      keep    = 4'hF;
      last    = 1'b0;
      rdy     = 2'b00;
      size    = 24'd0;
`ifdef AXI_KEEP_ERROR_EN
      kclear  = 1'b0;
`endif
      tick();
      tick();
      chk("rst_act", 64'(act), 64'd0);
      chk("rst_stb", 64'(stb), 64'd0);
      chk("rst_data", 64'(pdata), 64'd0);
      chk("rst_ready", 64'(ready), 64'd0);

      // Basic fill: buffer 0, size 4, tlast on the 4th beat.
      rdy  = 2'b01;
      size = 24'd4;
      rst  = 1'b0;
      tick();
      chk("t1_claim_act", 64'(act), 64'd1);
      chk("t1_claim_ready", 64'(ready), 64'd1);
      rdy = 2'b00;
      beat(32'h11, 1'b0, "t1_b1");
      beat(32'h22, 1'b0, "t1_b2");
      beat(32'h33, 1'b0, "t1_b3");
      beat(32'h44, 1'b1, "t1_b4");
      chk("t1_act_after_1", 64'(act), 64'd1);
      chk("t1_ready_rel", 64'(ready), 64'd0);
      tick();
      chk("t1_act_after_2", 64'(act), 64'd0);
      chk("t1_stb_idle", 64'(stb), 64'd0);

      // Early tlast: size 8, 3 beats.
      rdy  = 2'b01;
      size = 24'd8;
      tick();
      chk("t2_claim_act", 64'(act), 64'd1);
      rdy = 2'b00;
      beat(32'hAA, 1'b0, "t2_b1");
      beat(32'hBB, 1'b0, "t2_b2");
      beat(32'hCC, 1'b1, "t2_b3");
      chk("t2_ready_rel", 64'(ready), 64'd0);
      tick();
      chk("t2_act_idle", 64'(act), 64'd0);
      chk("t2_ready_idle", 64'(ready), 64'd0);
      tick();
      chk("t2_ready_noclaim", 64'(ready), 64'd0);
      chk("t2_stb_noclaim", 64'(stb), 64'd0);

      // Full without tlast: size 2, packet spans three buffers.
      rdy  = 2'b11;
      size = 24'd2;
      tick();
      chk("t3_claim0", 64'(act), 64'd1);
      rdy = 2'b10;
      beat(32'h01, 1'b0, "t3_w1");
      beat(32'h02, 1'b0, "t3_w2");
      chk("t3_full0_act", 64'(act), 64'd1);
      chk("t3_full0_ready", 64'(ready), 64'd0);
      tick();
      chk("t3_gap0_act", 64'(act), 64'd0);
      chk("t3_gap0_ready", 64'(ready), 64'd0);
      tick();
      chk("t3_claim1", 64'(act), 64'd2);
      chk("t3_claim1_ready", 64'(ready), 64'd1);
      beat(32'h03, 1'b0, "t3_w3");
      beat(32'h04, 1'b0, "t3_w4");
      rdy = 2'b01;
      chk("t3_full1_ready", 64'(ready), 64'd0);
      tick();
      chk("t3_gap1_act", 64'(act), 64'd0);
      chk("t3_gap1_ready", 64'(ready), 64'd0);
      tick();
      chk("t3_claim0b", 64'(act), 64'd1);
      rdy = 2'b00;
      beat(32'h05, 1'b0, "t3_w5");
      chk("t3_room_ready", 64'(ready), 64'd1);
      tick();
      chk("t3_hold_stb", 64'(stb), 64'd0);
      chk("t3_hold_act", 64'(act), 64'd1);
      beat(32'h06, 1'b1, "t3_w6");
      tick();
      chk("t3_end_act", 64'(act), 64'd0);

      // Backpressure: valid 1,0,1,0,1 with tlast on the last beat.
      rdy  = 2'b01;
      size = 24'd4;
      tick();
      rdy = 2'b00;
      beat(32'hA1, 1'b0, "t4_b1");
      tick();
      chk("t4_gap1_stb", 64'(stb), 64'd0);
      beat(32'hA2, 1'b0, "t4_b2");
      tick();
      chk("t4_gap2_stb", 64'(stb), 64'd0);
      chk("t4_gap2_ready", 64'(ready), 64'd1);
      beat(32'hA3, 1'b1, "t4_b3");
      tick();
      chk("t4_end_act", 64'(act), 64'd0);
      chk("t4_end_stb", 64'(stb), 64'd0);

      // Zero-size buffer: act high for two cycles, no strobe even with valid held.
      rdy   = 2'b01;
      size  = 24'd0;
      valid = 1'b1;
      data  = 32'hDEAD;
      tick();
      chk("t5_z_act1", 64'(act), 64'd1);
      chk("t5_z_ready", 64'(ready), 64'd0);
      rdy = 2'b00;
      tick();
      chk("t5_z_act2", 64'(act), 64'd1);
      chk("t5_z_stb2", 64'(stb), 64'd0);
      tick();
      chk("t5_z_act3", 64'(act), 64'd0);
      chk("t5_z_stb3", 64'(stb), 64'd0);
      valid = 1'b0;

      // Reset after 2 of 4 beats, with a third beat offered on the reset edge.
      rdy  = 2'b01;
      size = 24'd4;
      tick();
      rdy = 2'b00;
      beat(32'hB1, 1'b0, "t6_b1");
      beat(32'hB2, 1'b0, "t6_b2");
      valid = 1'b1;
      data  = 32'hB3;
      rst   = 1'b1;
      tick();
      chk("t6_rst_act", 64'(act), 64'd0);
      chk("t6_rst_stb", 64'(stb), 64'd0);
      chk("t6_rst_ready", 64'(ready), 64'd0);
      rst   = 1'b0;
      valid = 1'b0;
      tick();
      chk("t6_post_act", 64'(act), 64'd0);

`ifdef AXI_KEEP_ERROR_EN
      chk("k_rst_count", 64'(kcount), 64'd0);
      rdy  = 2'b01;
      size = 24'd8;
      tick();
      rdy  = 2'b00;
      keep = 4'b0111;
      beat(32'hC1, 1'b0, "k_b1");
      beat(32'hC2, 1'b0, "k_b2");
      beat(32'hC3, 1'b0, "k_b3");
      keep = 4'b1111;
      beat(32'hC4, 1'b0, "k_b4");
      chk("k_count3", 64'(kcount), 64'd3);
      keep   = 4'b0111;
      kclear = 1'b1;
      beat(32'hC5, 1'b0, "k_b5");
      chk("k_clear_wins", 64'(kcount), 64'd0);
      kclear = 1'b0;
      beat(32'hC6, 1'b0, "k_b6");
      chk("k_count1", 64'(kcount), 64'd1);
      keep = 4'b1111;
      beat(32'hC7, 1'b1, "k_b7");
      chk("k_count_hold", 64'(kcount), 64'd1);
      tick();
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
